path_delay_filter: RTL and testbench

//  Synthesizable model of one specify-block module path (e.g. (C=>Q)=(tPLH,tPHL)), in clk cycles.

---
 rtl/path_delay_pkg.sv | 31 +++
 rtl/pd_sat_counter.sv | 44 ++++
 rtl/path_delay_filter.sv | 175 +++++++++++++++++
 tb/tb_path_delay_filter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/path_delay_pkg.sv
// Shared types for the path_delay_filter slice.
//   pd_state_e : FSM states of the single-pending-event path model
//   pd_cfg_t   : configuration snapshot (rise/fall delay, reject limit,
//                pulse style, cancelled-pulse visibility)
//   pd_pick_delay : selects the rise or fall delay for a given target level
package path_delay_pkg;

  localparam int PD_DELAY_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    ERR_WAIT = 2'd2,
    ERR_SHOW = 2'd3
  } pd_state_e;

  typedef struct packed {
    logic [PD_DELAY_W-1:0] rise;
    logic [PD_DELAY_W-1:0] fall;
    logic [PD_DELAY_W-1:0] reject;
    logic                  ondetect;
    logic                  showcancel;
  } pd_cfg_t;

  // A transition towards 1 uses the rise delay, towards 0 the fall delay.
  function automatic logic [PD_DELAY_W-1:0] pd_pick_delay(input pd_cfg_t cfg,
                                                         input logic    tgt);
    return tgt ? cfg.rise : cfg.fall;
  endfunction

endpackage

// File: rtl/pd_sat_counter.sv
// Saturating load/decrement/increment counter.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (highest priority)
//   dec       : decrement, sticks at 0
//   inc       : increment, sticks at all-ones
//   cnt       : current count
module pd_sat_counter
  import path_delay_pkg::*;
#(
  parameter int W = PD_DELAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      if (cnt_q != '0) cnt_d = cnt_q - W'(1);
    end else if (inc) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/path_delay_filter.sv
// One specify-block module path modelled in clock cycles.
// The 1-bit path input is delayed by the rise/fall latency; pulses that
// are cancelled before they reach the output are either silently dropped
// (narrower than the reject limit, or noshowcancelled) or reported on
// out_err for as many cycles as the pulse was wide, either right after
// detection (ondetect) or from the edge the output would have changed
// (onevent).
//   clk, rst        : clock, synchronous active-high reset
//   in_sig          : path source
//   cfg_rise/fall   : 0->1 / 1->0 delay in cycles
//   cfg_reject      : pulse reject limit (0 = never reject)
//   cfg_ondetect    : 1 = report on detect, 0 = report at scheduled edge
//   cfg_showcancel  : 1 = report cancelled pulses on out_err
//   out_sig         : delayed path output
//   out_err         : cancelled-pulse indication
//   busy            : an event is pending or being reported
//   cancel_cnt      : saturating count of reported cancellations
module path_delay_filter
  import path_delay_pkg::*;
#(
  parameter int   DELAY_W   = PD_DELAY_W,
  parameter logic RESET_VAL = 1'b0,
  parameter int   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_sig,
  input  logic [DELAY_W-1:0] cfg_rise,
  input  logic [DELAY_W-1:0] cfg_fall,
  input  logic [DELAY_W-1:0] cfg_reject,
  input  logic               cfg_ondetect,
  input  logic               cfg_showcancel,
  output logic               out_sig,
  output logic               out_err,
  output logic               busy,
  output logic [CNT_W-1:0]   cancel_cnt
);

  localparam logic [DELAY_W-1:0] ONE     = DELAY_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  pd_state_e          state_q, state_d;
  pd_cfg_t            cfg_q, cfg_d;
  logic               in_q, in_d;
  logic               out_q, out_d;
  logic               tgt_q, tgt_d;
  logic [CNT_W-1:0]   cancel_cnt_q, cancel_cnt_d;

  logic [DELAY_W-1:0] sched_delay;
  logic [DELAY_W-1:0] rem;
  logic [DELAY_W-1:0] w;
  logic               rem_load, rem_dec;
  logic               w_load, w_inc, w_dec;

  // Remaining cycles until the pending event reaches out_sig.
  pd_sat_counter #(.W(DELAY_W)) u_rem (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load),
    .load_val (sched_delay),
    .dec      (rem_dec),
    .inc      (1'b0),
    .cnt      (rem)
  );

  // Width of the pulse being tracked; later reused as the error-show timer.
  pd_sat_counter #(.W(DELAY_W)) u_w (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (ONE),
    .dec      (w_dec),
    .inc      (w_inc),
    .cnt      (w)
  );

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    in_d         = in_sig;
    out_d        = out_q;
    tgt_d        = tgt_q;
    cancel_cnt_d = cancel_cnt_q;
    rem_load     = 1'b0;
    rem_dec      = 1'b0;
    w_load       = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    sched_delay  = pd_pick_delay(cfg_q, in_q);

    unique case (state_q)
      IDLE: begin
        // in_q is the value sampled on the previous edge, so scheduling one
        // edge later and expiring when rem hits 0 yields latency d+1.
        if (in_q != out_q) begin
          if (sched_delay == '0) begin
            out_d = in_q;
          end else begin
            tgt_d    = in_q;
            rem_load = 1'b1;
            w_load   = 1'b1;
            state_d  = PEND;
          end
        end
      end
      PEND: begin
        if (rem <= ONE) begin
          // Expiry takes priority over a reversion seen on the same edge.
          out_d   = tgt_q;
          state_d = IDLE;
        end else if (in_q != tgt_q) begin
          if (!cfg_q.showcancel || (w < cfg_q.reject)) begin
            state_d = IDLE;
          end else begin
            if (cancel_cnt_q != CNT_MAX) cancel_cnt_d = cancel_cnt_q + CNT_W'(1);
            if (cfg_q.ondetect) begin
              state_d = ERR_SHOW;
            end else begin
              // Keep counting so the report starts on the original edge.
              rem_dec = 1'b1;
              state_d = ERR_WAIT;
            end
          end
        end else begin
          rem_dec = 1'b1;
          w_inc   = 1'b1;
        end
      end
      ERR_WAIT: begin
        if (rem <= ONE) state_d = ERR_SHOW;
        else            rem_dec = 1'b1;
      end
      ERR_SHOW: begin
        if (w <= ONE) state_d = IDLE;
        else          w_dec   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Config tracks the inputs while idle and is frozen for the whole life
    // of an event, so the snapshot used is the one present when the
    // in_sig change was sampled.
    if (state_d == IDLE) begin
      cfg_d.rise       = cfg_rise;
      cfg_d.fall       = cfg_fall;
      cfg_d.reject     = cfg_reject;
      cfg_d.ondetect   = cfg_ondetect;
      cfg_d.showcancel = cfg_showcancel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      in_q         <= RESET_VAL;
      out_q        <= RESET_VAL;
      tgt_q        <= RESET_VAL;
      cancel_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      in_q         <= in_d;
      out_q        <= out_d;
      tgt_q        <= tgt_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  assign out_sig    = out_q;
  assign out_err    = (state_q == ERR_SHOW);
  assign busy       = (state_q != IDLE);
  assign cancel_cnt = cancel_cnt_q;

endmodule

// File: tb/tb_path_delay_filter.sv
// Directed bench for path_delay_filter. Edge k below is the first clock
// edge that samples a new in_sig value; outputs are checked 1 time unit
// after an edge.
module tb_path_delay_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sig;
  logic [7:0]  cfg_rise, cfg_fall, cfg_reject;
  logic        cfg_ondetect, cfg_showcancel;
  logic        out_sig, out_err, busy;
  logic [15:0] cancel_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  path_delay_filter #(.DELAY_W(8), .RESET_VAL(1'b0), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sig         (in_sig),
    .cfg_rise       (cfg_rise),
    .cfg_fall       (cfg_fall),
    .cfg_reject     (cfg_reject),
    .cfg_ondetect   (cfg_ondetect),
    .cfg_showcancel (cfg_showcancel),
    .out_sig        (out_sig),
    .out_err        (out_err),
    .busy           (busy),
    .cancel_cnt     (cancel_cnt)
  );

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply a configuration and give the idle DUT time to take it.
  task automatic set_cfg(input logic [7:0] r, input logic [7:0] f,
                         input logic [7:0] rej, input logic ond,
                         input logic show);
    cfg_rise       = r;
    cfg_fall       = f;
    cfg_reject     = rej;
    cfg_ondetect   = ond;
    cfg_showcancel = show;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; in_sig = 1'b0;
    cfg_rise = '0; cfg_fall = '0; cfg_reject = '0;
    cfg_ondetect = 1'b0; cfg_showcancel = 1'b0;
    tick(3);
    check_value("rst_out",  32'(out_sig), 32'd0);
    check_value("rst_err",  32'(out_err), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_cnt",  32'(cancel_cnt), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: rise=3 -> out at k+4, fall=5 -> out at k+6
    set_cfg(8'd3, 8'd5, 8'd0, 1'b0, 1'b0);
    in_sig = 1'b1;
    tick(1); check_value("t1_busy_k",   32'(busy), 32'd0);
    tick(1); check_value("t1_busy_k1",  32'(busy), 32'd1);
    tick(2); check_value("t1_out_k3",   32'(out_sig), 32'd0);
    tick(1); check_value("t1_out_k4",   32'(out_sig), 32'd1);
             check_value("t1_idle_k4",  32'(busy), 32'd0);
    in_sig = 1'b0;
    tick(6); check_value("t1_out_f5",   32'(out_sig), 32'd1);
    tick(1); check_value("t1_out_f6",   32'(out_sig), 32'd0);

    // 2: 1-cycle pulse with reject=2 is dropped
    set_cfg(8'd4, 8'd4, 8'd2, 1'b1, 1'b1);
    in_sig = 1'b1;
    tick(1); in_sig = 1'b0;
    tick(1); check_value("t2_busy_k1",  32'(busy), 32'd1);
    tick(1); check_value("t2_busy_k2",  32'(busy), 32'd0);
    tick(5); check_value("t2_out",      32'(out_sig), 32'd0);
             check_value("t2_err",      32'(out_err), 32'd0);
             check_value("t2_cnt",      32'(cancel_cnt), 32'd0);

    // 3: ondetect, 3-cycle pulse -> out_err after k+4..k+6
    set_cfg(8'd6, 8'd6, 8'd2, 1'b1, 1'b1);
    in_sig = 1'b1;
    tick(3); in_sig = 1'b0;
    tick(1); check_value("t3_err_k3",   32'(out_err), 32'd0);
             check_value("t3_busy_k3",  32'(busy), 32'd1);
    tick(1); check_value("t3_err_k4",   32'(out_err), 32'd1);
             check_value("t3_cnt",      32'(cancel_cnt), 32'd1);
    tick(2); check_value("t3_err_k6",   32'(out_err), 32'd1);
             check_value("t3_out_k6",   32'(out_sig), 32'd0);
    tick(1); check_value("t3_err_k7",   32'(out_err), 32'd0);
             check_value("t3_busy_k7",  32'(busy), 32'd0);

    // 4: onevent -> out_err from scheduled edge k+7 for 3 cycles
    set_cfg(8'd6, 8'd6, 8'd2, 1'b0, 1'b1);
    in_sig = 1'b1;
    tick(3); in_sig = 1'b0;
    tick(2); check_value("t4_err_k4",   32'(out_err), 32'd0);
             check_value("t4_busy_k4",  32'(busy), 32'd1);
             check_value("t4_cnt",      32'(cancel_cnt), 32'd2);
    tick(2); check_value("t4_err_k6",   32'(out_err), 32'd0);
    tick(1); check_value("t4_err_k7",   32'(out_err), 32'd1);
    tick(2); check_value("t4_err_k9",   32'(out_err), 32'd1);
    tick(1); check_value("t4_err_k10",  32'(out_err), 32'd0);
             check_value("t4_busy_k10", 32'(busy), 32'd0);
             check_value("t4_out_k10",  32'(out_sig), 32'd0);

    // noshowcancelled: wide pulse dropped silently
    set_cfg(8'd6, 8'd6, 8'd2, 1'b1, 1'b0);
    in_sig = 1'b1;
    tick(3); in_sig = 1'b0;
    tick(2); check_value("nsc_busy",    32'(busy), 32'd0);
             check_value("nsc_err",     32'(out_err), 32'd0);
             check_value("nsc_cnt",     32'(cancel_cnt), 32'd2);

    // 5: rise=2, pulse reverts on expiry edge; fall=0 reschedules at once
    set_cfg(8'd2, 8'd0, 8'd0, 1'b0, 1'b0);
    in_sig = 1'b1;
    tick(2); in_sig = 1'b0;
    tick(1); check_value("t5_out_k2",   32'(out_sig), 32'd0);
             check_value("t5_busy_k2",  32'(busy), 32'd1);
    tick(1); check_value("t5_out_k3",   32'(out_sig), 32'd1);
    tick(1); check_value("t5_out_k4",   32'(out_sig), 32'd0);
             check_value("t5_busy_k4",  32'(busy), 32'd0);

    // d=0 -> latency 1
    set_cfg(8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    in_sig = 1'b1;
    tick(1); check_value("d0_out_k",    32'(out_sig), 32'd0);
    tick(1); check_value("d0_out_k1",   32'(out_sig), 32'd1);
             check_value("d0_busy_k1",  32'(busy), 32'd0);
    in_sig = 1'b0;
    tick(2); check_value("d0_out_fall", 32'(out_sig), 32'd0);

    // 6a: reset while pending discards the event
    set_cfg(8'd5, 8'd5, 8'd0, 1'b0, 1'b0);
    in_sig = 1'b1;
    tick(3); check_value("t6_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1; in_sig = 1'b0;
    tick(1); check_value("t6_rst_out",  32'(out_sig), 32'd0);
             check_value("t6_rst_busy", 32'(busy), 32'd0);
             check_value("t6_rst_cnt",  32'(cancel_cnt), 32'd0);
    rst = 1'b0;
    tick(3); check_value("t6_post_out", 32'(out_sig), 32'd0);

    // 6b: config change while pending keeps the latched delay
    set_cfg(8'd5, 8'd5, 8'd0, 1'b0, 1'b0);
    in_sig = 1'b1;
    tick(2); check_value("t6_busy_k1",  32'(busy), 32'd1);
    cfg_rise = 8'd1;
    tick(4); check_value("t6_out_k5",   32'(out_sig), 32'd0);
    tick(1); check_value("t6_out_k6",   32'(out_sig), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
